// File: rtl/uart_cmd_pkg.sv
// Shared types and ASCII constants for the UART/button command scheduler.
package uart_cmd_pkg;

  typedef enum logic [2:0] {IDLE, DECODE, ISSUE, ACK, GAP} state_t;
  typedef enum logic [2:0] {NONE, ENABLE, CLEAR, MODE, IGNORE, UNKNOWN} cmd_t;
  typedef enum logic {BTN, UART} src_t;

  localparam logic [7:0] ASC_E_UP = 8'h45;
  localparam logic [7:0] ASC_E_LO = 8'h65;
  localparam logic [7:0] ASC_C_UP = 8'h43;
  localparam logic [7:0] ASC_C_LO = 8'h63;
  localparam logic [7:0] ASC_M_UP = 8'h4D;
  localparam logic [7:0] ASC_M_LO = 8'h6D;
  localparam logic [7:0] ASC_CR   = 8'h0D;
  localparam logic [7:0] ASC_LF   = 8'h0A;
  localparam logic [7:0] ACK_ERR  = 8'h3F;

  // Ack byte echoed for a command: its uppercase letter, '?' for anything else.
  function automatic logic [7:0] cmd_ack_byte(input cmd_t c);
    case (c)
      ENABLE:  return ASC_E_UP;
      CLEAR:   return ASC_C_UP;
      MODE:    return ASC_M_UP;
      default: return ACK_ERR;
    endcase
  endfunction

endpackage

// File: rtl/uart_cmd_scheduler_if.sv
// FIFO-side bus of the scheduler: show-ahead RX FIFO read port and TX FIFO write port.
// Handshake: a byte leaves RX on a cycle with o_rx_pop=1 and i_rx_empty=0; a byte enters
// TX on a cycle with o_tx_push=1, which is only ever raised while i_tx_full=0.
interface uart_cmd_scheduler_if;
  logic       i_rx_empty;
  logic [7:0] i_rx_data;
  logic       o_rx_pop;
  logic       i_tx_full;
  logic       o_tx_push;
  logic [7:0] o_tx_data;

  modport master (
    input  i_rx_empty, i_rx_data, i_tx_full,
    output o_rx_pop, o_tx_push, o_tx_data
  );

  modport slave (
    output i_rx_empty, i_rx_data, i_tx_full,
    input  o_rx_pop, o_tx_push, o_tx_data
  );
endinterface

// File: rtl/ascii_cmd_decoder.sv
// Combinational map from a received ASCII byte to a scheduler command and its ack byte.
module ascii_cmd_decoder
  import uart_cmd_pkg::*;
(
  input  logic [7:0] i_byte,
  output cmd_t       o_cmd,
  output logic [7:0] o_ack
);

  always_comb begin
    o_cmd = UNKNOWN;
    case (i_byte)
      ASC_E_UP, ASC_E_LO: o_cmd = ENABLE;
      ASC_C_UP, ASC_C_LO: o_cmd = CLEAR;
      ASC_M_UP, ASC_M_LO: o_cmd = MODE;
      ASC_CR, ASC_LF:     o_cmd = IGNORE;
      default:            o_cmd = UNKNOWN;
    endcase
    o_ack = cmd_ack_byte(o_cmd);
  end

endmodule

// File: rtl/uart_cmd_scheduler.sv
// Arbitrates button and UART commands into spaced one-cycle pulses for the counter
// control unit, with optional ack echo to the TX FIFO and an unknown-byte counter.
module uart_cmd_scheduler
  import uart_cmd_pkg::*;
#(
  parameter int GAP_CYC = 2,
  parameter bit ECHO_EN = 1'b1,
  parameter int ERR_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_btn_enable,
  input  logic                 i_btn_clear,
  input  logic                 i_btn_mode,
  uart_cmd_scheduler_if.master fifo,
  output logic                 o_enable,
  output logic                 o_clear,
  output logic                 o_mode,
  output logic                 o_busy,
  output logic [ERR_W-1:0]     o_err_cnt,
  output state_t               o_state
);

  localparam int GW = $clog2(GAP_CYC + 1);

  state_t           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  src_t             last_src_q, last_src_d;
  logic [7:0]       byte_q, byte_d;
  logic [7:0]       ack_q, ack_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [2:0]       pend_q, pend_d;

  logic [2:0] pend_clr;
  logic       btn_req, uart_req, rx_pop;
  cmd_t       dec_cmd;
  logic [7:0] dec_ack;

  ascii_cmd_decoder u_dec (
    .i_byte (byte_q),
    .o_cmd  (dec_cmd),
    .o_ack  (dec_ack)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cmd_q      <= NONE;
      last_src_q <= UART;
      byte_q     <= '0;
      ack_q      <= '0;
      err_q      <= '0;
      gap_q      <= '0;
      pend_q     <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      last_src_q <= last_src_d;
      byte_q     <= byte_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      gap_q      <= gap_d;
      pend_q     <= pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    last_src_d = last_src_q;
    byte_d     = byte_q;
    ack_d      = ack_q;
    err_d      = err_q;
    gap_d      = gap_q;
    pend_clr   = '0;
    rx_pop     = 1'b0;
    btn_req    = |pend_q;
    uart_req   = !fifo.i_rx_empty;

    case (state_q)
      IDLE: begin
        // On a tie the source that was not served last wins.
        if (btn_req && (!uart_req || last_src_q == UART)) begin
          state_d    = ISSUE;
          last_src_d = BTN;
          if (pend_q[0]) begin
            cmd_d    = ENABLE;
            pend_clr = 3'b001;
          end else if (pend_q[1]) begin
            cmd_d    = CLEAR;
            pend_clr = 3'b010;
          end else begin
            cmd_d    = MODE;
            pend_clr = 3'b100;
          end
        end else if (uart_req) begin
          rx_pop     = 1'b1;
          byte_d     = fifo.i_rx_data;
          state_d    = DECODE;
          last_src_d = UART;
        end
      end
      DECODE: begin
        gap_d = '0;
        cmd_d = dec_cmd;
        case (dec_cmd)
          ENABLE, CLEAR, MODE: begin
            ack_d   = dec_ack;
            state_d = ISSUE;
          end
          IGNORE: state_d = GAP;
          default: begin
            if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
            ack_d   = ACK_ERR;
            state_d = ECHO_EN ? ACK : GAP;
          end
        endcase
      end
      ISSUE: begin
        gap_d   = '0;
        state_d = (last_src_q == UART && ECHO_EN) ? ACK : GAP;
      end
      ACK: begin
        gap_d = '0;
        if (!fifo.i_tx_full) state_d = GAP;
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYC - 1)) state_d = IDLE;
        else                           gap_d   = gap_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase

    // A pulse in the same cycle as the serving grant re-arms the latch.
    pend_d = (pend_q & ~pend_clr) | {i_btn_mode, i_btn_clear, i_btn_enable};
  end

  assign o_enable       = (state_q == ISSUE) && (cmd_q == ENABLE);
  assign o_clear        = (state_q == ISSUE) && (cmd_q == CLEAR);
  assign o_mode         = (state_q == ISSUE) && (cmd_q == MODE);
  assign o_busy         = (state_q != IDLE);
  assign o_err_cnt      = err_q;
  assign o_state        = state_q;
  assign fifo.o_rx_pop  = rx_pop & rst;
  assign fifo.o_tx_push = (state_q == ACK) && !fifo.i_tx_full;
  assign fifo.o_tx_data = ack_q;

endmodule

// File: tb/tb_uart_cmd_scheduler.sv
// Directed bench for uart_cmd_scheduler: byte decode table plus button, contention,
// backpressure, saturation and async-reset sequences; TX pushes checked against exp_q.
module tb_uart_cmd_scheduler;
  import uart_cmd_pkg::*;

  localparam int GAP_CYC = 2;
  localparam int ERR_W   = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_enable = 1'b0, btn_clear = 1'b0, btn_mode = 1'b0;
  logic o_enable, o_clear, o_mode, o_busy;
  logic [ERR_W-1:0] o_err_cnt;
  state_t o_state;

  uart_cmd_scheduler_if fifo ();

  uart_cmd_scheduler #(.GAP_CYC(GAP_CYC), .ECHO_EN(1'b1), .ERR_W(ERR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_btn_enable (btn_enable),
    .i_btn_clear  (btn_clear),
    .i_btn_mode   (btn_mode),
    .fifo         (fifo.master),
    .o_enable     (o_enable),
    .o_clear      (o_clear),
    .o_mode       (o_mode),
    .o_busy       (o_busy),
    .o_err_cnt    (o_err_cnt),
    .o_state      (o_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // scoreboard: every TX push must match the next expected ack byte
  always @(negedge clk) begin
    if (rst && fifo.o_tx_push) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tx_push_unexpected: got data %0h expected no push", fifo.o_tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (fifo.o_tx_data !== e) begin
          errors++;
          $display("FAIL tx_data: got %0h expected %0h", fifo.o_tx_data, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    btn_enable = 1'b0; btn_clear = 1'b0; btn_mode = 1'b0;
    fifo.i_rx_empty = 1'b1; fifo.i_rx_data = 8'h00; fifo.i_tx_full = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic wait_pop();
    int n = 0;
    while (fifo.o_rx_pop !== 1'b1 && n < 20) begin
      step(); #1; n++;
    end
    check("rx_pop_seen", 32'(fifo.o_rx_pop), 32'd1);
  endtask

  task automatic run_byte(input logic [7:0] b, input logic [2:0] exp_pulse,
                          input logic exp_push, input logic [7:0] exp_data,
                          input logic [7:0] exp_err);
    int extra = 0;
    int pushes = 0;
    fifo.i_rx_data = b; fifo.i_rx_empty = 1'b0;
    if (exp_push) exp_q.push_back(exp_data);
    #1;
    wait_pop();
    step(); fifo.i_rx_empty = 1'b1;
    step(); #1;
    for (int k = 0; k < 8; k++) begin
      if (k == 0) check($sformatf("pulse_%02h", b), 32'({o_mode, o_clear, o_enable}), 32'(exp_pulse));
      else if (o_mode || o_clear || o_enable) extra++;
      if (fifo.o_tx_push) pushes++;
      step(); #1;
    end
    check($sformatf("extra_pulse_%02h", b), 32'(extra), 32'd0);
    check($sformatf("push_cnt_%02h", b), 32'(pushes), 32'(exp_push));
    check($sformatf("err_cnt_%02h", b), 32'(o_err_cnt), 32'(exp_err));
    check($sformatf("idle_after_%02h", b), 32'(o_busy), 32'd0);
  endtask

  typedef struct {
    logic [7:0] b;
    logic [2:0] pulse;
    logic       push;
    logic [7:0] data;
    logic [7:0] err;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int c0, t_mode, t_clear, n_mode, n_clear, bad;
    logic pop_now;
    logic [7:0] exp_err;

    // {byte, {mode,clear,enable}, push, ack, err_cnt after}
    vecs[0]  = '{8'h0D, 3'b000, 1'b0, 8'h00, 8'd0};
    vecs[1]  = '{8'h5A, 3'b000, 1'b1, 8'h3F, 8'd1};
    vecs[2]  = '{8'h65, 3'b001, 1'b1, 8'h45, 8'd1};
    vecs[3]  = '{8'h45, 3'b001, 1'b1, 8'h45, 8'd1};
    vecs[4]  = '{8'h63, 3'b010, 1'b1, 8'h43, 8'd1};
    vecs[5]  = '{8'h43, 3'b010, 1'b1, 8'h43, 8'd1};
    vecs[6]  = '{8'h6D, 3'b100, 1'b1, 8'h4D, 8'd1};
    vecs[7]  = '{8'h4D, 3'b100, 1'b1, 8'h4D, 8'd1};
    vecs[8]  = '{8'h0A, 3'b000, 1'b0, 8'h00, 8'd1};
    vecs[9]  = '{8'h00, 3'b000, 1'b1, 8'h3F, 8'd2};
    vecs[10] = '{8'hFF, 3'b000, 1'b1, 8'h3F, 8'd3};
    vecs[11] = '{8'h6E, 3'b000, 1'b1, 8'h3F, 8'd4};
    vecs[12] = '{8'h44, 3'b000, 1'b1, 8'h3F, 8'd5};

    fifo.i_rx_empty = 1'b1; fifo.i_rx_data = 8'h00; fifo.i_tx_full = 1'b0;
    #2;
    check("rst_pulses", 32'({o_mode, o_clear, o_enable}), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_state", 32'(o_state), 32'(IDLE));
    check("rst_err", 32'(o_err_cnt), 32'd0);
    check("rst_tx", 32'({fifo.o_tx_push, fifo.o_rx_pop, fifo.o_tx_data}), 32'd0);
    do_reset();

    // single button clear: pulse in c0, o_clear in c0+2
    step();
    btn_clear = 1'b1; c0 = cyc; #1;
    check("btn_busy_before", 32'(o_busy), 32'd0);
    step(); btn_clear = 1'b0; #1;
    check("btn_no_early_pulse", 32'({o_mode, o_clear, o_enable}), 32'd0);
    step(); #1;
    check("btn_clear_at_n2", 32'({o_mode, o_clear, o_enable}), 32'b010);
    check("btn_busy_issue", 32'(o_busy), 32'd1);
    check("btn_issue_cycle", 32'(cyc - c0), 32'd2);
    step(); #1;
    check("btn_gap1", 32'({o_busy, o_mode, o_clear, o_enable}), 32'b1000);
    step(); #1;
    check("btn_gap2", 32'({o_busy, o_mode, o_clear, o_enable}), 32'b1000);
    step(); step(); #1;
    check("btn_idle_again", 32'(o_busy), 32'd0);

    // decode table through the full UART path
    for (int i = 0; i < 13; i++)
      run_byte(vecs[i].b, vecs[i].pulse, vecs[i].push, vecs[i].data, vecs[i].err);

    // contention: mode pending and 'C' waiting together, buttons win the first tie
    do_reset();
    btn_mode = 1'b1; #1;
    step(); btn_mode = 1'b0;
    fifo.i_rx_data = 8'h43; fifo.i_rx_empty = 1'b0; exp_q.push_back(8'h43);
    t_mode = -1; t_clear = -1; n_mode = 0; n_clear = 0;
    for (int k = 1; k <= 15; k++) begin
      #1;
      if (o_mode) begin t_mode = k; n_mode++; end
      if (o_clear) begin t_clear = k; n_clear++; end
      pop_now = fifo.o_rx_pop;
      step();
      if (pop_now) fifo.i_rx_empty = 1'b1;
    end
    check("cont_mode_cycle", 32'(t_mode), 32'd2);
    check("cont_clear_cycle", 32'(t_clear), 32'd7);
    check("cont_spacing", 32'((t_clear - t_mode) >= GAP_CYC + 2), 32'd1);
    check("cont_counts", 32'({n_mode[3:0], n_clear[3:0]}), 32'h11);

    // TX backpressure during ACK, with a button press landing in the stall
    fifo.i_rx_data = 8'h6D; fifo.i_rx_empty = 1'b0; exp_q.push_back(8'h4D);
    #1;
    wait_pop();
    step(); fifo.i_rx_empty = 1'b1; fifo.i_tx_full = 1'b1;
    step(); #1;
    check("bp_mode_pulse", 32'({o_mode, o_clear, o_enable}), 32'b100);
    step();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (fifo.o_tx_push !== 1'b0 || fifo.o_tx_data !== 8'h4D || o_state !== ACK) bad++;
      step();
      btn_enable = (i == 4);
    end
    check("bp_stall_cycles_bad", 32'(bad), 32'd0);
    fifo.i_tx_full = 1'b0; #1;
    check("bp_push_on_release", 32'({fifo.o_tx_push, fifo.o_tx_data}), 32'h14D);
    step(); #1;
    check("bp_gap_after_push", 32'(o_state), 32'(GAP));
    step(); step(); step(); #1;
    check("bp_btn_enable_issued", 32'({o_mode, o_clear, o_enable}), 32'b001);

    // saturating error counter: 256 unknown bytes from zero
    step(); step(); step(); step();
    exp_err = 8'd0;
    for (int i = 0; i < 256; i++) begin
      exp_err = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
      run_byte(8'h5A, 3'b000, 1'b1, 8'h3F, exp_err);
    end
    check("sat_final", 32'(o_err_cnt), 32'hFF);

    // async reset while stalled in ACK: nothing survives
    fifo.i_rx_data = 8'h65; fifo.i_rx_empty = 1'b0; #1;
    wait_pop();
    step(); fifo.i_rx_empty = 1'b1; fifo.i_tx_full = 1'b1;
    step(); #1;
    check("ar_enable_pulse", 32'({o_mode, o_clear, o_enable}), 32'b001);
    step(); step(); #1;
    check("ar_in_ack", 32'(o_state), 32'(ACK));
    #2; rst = 1'b0; #1;
    check("ar_state_idle", 32'(o_state), 32'(IDLE));
    check("ar_outputs_zero", 32'({o_busy, o_mode, o_clear, o_enable, fifo.o_tx_push, fifo.o_rx_pop}), 32'd0);
    check("ar_tx_data_zero", 32'(fifo.o_tx_data), 32'd0);
    check("ar_err_zero", 32'(o_err_cnt), 32'd0);
    step(); fifo.i_tx_full = 1'b0;
    step(); rst = 1'b1;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (o_mode || o_clear || o_enable || fifo.o_rx_pop || o_busy) bad++;
      step();
    end
    check("ar_no_leftover", 32'(bad), 32'd0);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
